// File: rtl/digit_feeder.sv
// digit_feeder: streams a latched signed-digit operand, MSD first, to a
// consumer that pulls digits on request while a step counter runs from 0 up
// to LAST_CNT. Missing requests and consumer corrections insert zero padding;
// digits still unissued when the counter reaches LAST_CNT are dropped.
module digit_feeder #(
  parameter int DIGITS   = 16,
  parameter int LAST_CNT = 67
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2*DIGITS-1:0]   operand_in,
  input  logic                  enable_for_input,
  input  logic                  error_flag,
  output logic [8:0]            cnt_master,
  output logic                  write_enable,
  output logic [1:0]            digit_out,
  output logic                  digit_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal_digit
);

  localparam int SW = 2 * DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [8:0] LAST_VAL    = 9'(LAST_CNT);
  localparam logic [6:0] DIGITS_INIT = 7'(DIGITS);

  logic [1:0]    state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [SW-1:0] shreg_q, shreg_d;
  logic [6:0]    left_q, left_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    digit_q, digit_d;
  logic          valid_q, valid_d;
  logic          ill_q, ill_d;

  logic          consume;
  logic [1:0]    msd;

  assign msd     = shreg_q[SW-1 -: 2];
  assign consume = enable_for_input && !error_flag && (left_q != 7'd0);

  // Next-state and next-output logic; every output is computed here one
  // cycle ahead so that the ports come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    left_d  = left_q;
    ill_d   = ill_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    digit_d = 2'b00;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          shreg_d = operand_in;
          left_d  = DIGITS_INIT;
          cnt_d   = 9'd0;
          ill_d   = 1'b0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_VAL) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 9'd1;
          we_d   = 1'b1;
          busy_d = 1'b1;
          if (consume) begin
            valid_d = 1'b1;
            shreg_d = shreg_q << 2;
            left_d  = left_q - 7'd1;
            if (msd == 2'b10) begin
              digit_d = 2'b00;
              ill_d   = 1'b1;
            end else begin
              digit_d = msd;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 9'd0;
      shreg_q <= '0;
      left_q  <= 7'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= 2'b00;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      left_q  <= left_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign cnt_master    = cnt_q;
  assign write_enable  = we_q;
  assign digit_out     = digit_q;
  assign digit_valid   = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign illegal_digit = ill_q;

endmodule

// File: tb/tb_digit_feeder.sv
// Testbench for digit_feeder. Two instances (LAST_CNT=7 and LAST_CNT=11,
// both DIGITS=4) share clock, reset, operand and consumer inputs but have
// separate start lines, so only one runs at a time.
module tb_digit_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [7:0] operand;
  logic       en, err;

  logic [8:0] a_cnt, b_cnt;
  logic       a_we, b_we, a_busy, b_busy, a_done, b_done;
  logic [1:0] a_dig, b_dig;
  logic       a_val, b_val, a_ill, b_ill;

  typedef struct packed {
    logic [8:0] cnt;
    logic       we;
    logic       busy;
    logic       done;
    logic [1:0] digit;
    logic       valid;
    logic       ill;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs;
  logic sel_b = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  digit_feeder #(.DIGITS(4), .LAST_CNT(7)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .operand_in(operand),
    .enable_for_input(en), .error_flag(err),
    .cnt_master(a_cnt), .write_enable(a_we), .digit_out(a_dig),
    .digit_valid(a_val), .busy(a_busy), .done(a_done), .illegal_digit(a_ill)
  );

  digit_feeder #(.DIGITS(4), .LAST_CNT(11)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .operand_in(operand),
    .enable_for_input(en), .error_flag(err),
    .cnt_master(b_cnt), .write_enable(b_we), .digit_out(b_dig),
    .digit_valid(b_val), .busy(b_busy), .done(b_done), .illegal_digit(b_ill)
  );

  // Observed outputs of whichever instance the current test targets
  always_comb begin
    obs = sel_b ? {b_cnt, b_we, b_busy, b_done, b_dig, b_val, b_ill}
                : {a_cnt, a_we, a_busy, a_done, a_dig, a_val, a_ill};
  end

  function automatic rec_t mk(input int cnt, input logic we, input logic bsy,
                              input logic dn, input logic [1:0] d,
                              input logic v, input logic il);
    rec_t r;
    r.cnt = 9'(cnt); r.we = we; r.busy = bsy; r.done = dn;
    r.digit = d; r.valid = v; r.ill = il;
    return r;
  endfunction

  // Consumer request pattern by step: 0 = always, 1 = every fourth step
  function automatic logic en_at(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return (k % 4) == 0;
  endfunction

  // Correction pattern by step: 0 = never, 1 = during steps 1 and 2
  function automatic logic err_at(input int mode, input int k);
    if (mode == 0) return 1'b0;
    return (k == 1) || (k == 2);
  endfunction

  task automatic report(input string name, input int cyc, input rec_t got, input rec_t want);
    $display("[TB] FAIL %s cyc=%0d got cnt=%0d we=%b busy=%b done=%b dig=%b val=%b ill=%b want cnt=%0d we=%b busy=%b done=%b dig=%b val=%b ill=%b",
             name, cyc, got.cnt, got.we, got.busy, got.done, got.digit, got.valid, got.ill,
             want.cnt, want.we, want.busy, want.done, want.digit, want.valid, want.ill);
  endtask

  // Pushes the expected per-cycle outputs of one whole operation: RUN steps
  // 0..last, the DONE cycle, and the first IDLE cycle.
  task automatic build_expected(input int last, input logic [7:0] op,
                                input int en_mode, input int err_mode);
    logic [7:0] sr;
    int         left;
    logic       il;
    logic [1:0] d;
    logic       v;
    sr = op; left = 4; il = 1'b0; d = 2'b00; v = 1'b0;
    exp_q.delete();
    for (int k = 0; k <= last; k++) begin
      exp_q.push_back(mk(k, 1'b1, 1'b1, 1'b0, d, v, il));
      d = 2'b00; v = 1'b0;
      if (k < last && en_at(en_mode, k) && !err_at(err_mode, k) && left > 0) begin
        v = 1'b1;
        if (sr[7:6] == 2'b10) begin
          il = 1'b1;
        end else begin
          d = sr[7:6];
        end
        sr = {sr[5:0], 2'b00};
        left--;
      end
    end
    exp_q.push_back(mk(last, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, il));
    exp_q.push_back(mk(last, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, il));
  endtask

  // Starts one operation on the chosen instance and checks every cycle
  // against the scoreboard. start_at >= 0 re-pulses start (with a different
  // operand) at that step to confirm it is ignored.
  task automatic run_op(input logic use_b, input int last, input logic [7:0] op,
                        input int en_mode, input int err_mode, input int start_at,
                        input string name);
    int   n;
    rec_t e;
    sel_b = use_b;
    build_expected(last, op, en_mode, err_mode);
    operand = op; en = 1'b0; err = 1'b0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        report(name, i, obs, e);
      end
      if (i == n - 1) break;
      operand = op;
      start_a = 1'b0; start_b = 1'b0;
      en  = (i <= last) ? en_at(en_mode, i)  : 1'b0;
      err = (i <= last) ? err_at(err_mode, i) : 1'b0;
      if (i == start_at) begin
        operand = ~op;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      @(posedge clk); #1;
    end
    en = 1'b0; err = 1'b0; start_a = 1'b0; start_b = 1'b0; operand = op;
  endtask

  task automatic test_reset();
    rec_t z;
    z = mk(0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    operand = 8'h00; en = 1'b0; err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel_b = (s == 1);
      #1;
      total++;
      if (obs !== z) begin bad++; report("reset_state", s, obs, z); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== z) begin bad++; report("idle_after_reset", 0, obs, z); end
  endtask

  task automatic test_full_stream();
    run_op(1'b0, 7, 8'b01_11_00_01, 0, 0, -1, "full_stream");
  endtask

  task automatic test_sparse_enable();
    run_op(1'b1, 11, 8'b01_11_00_01, 1, 0, -1, "sparse_enable");
  endtask

  task automatic test_error_stall();
    run_op(1'b1, 11, 8'b01_11_00_01, 0, 1, -1, "error_stall");
  endtask

  task automatic test_illegal();
    rec_t e;
    run_op(1'b1, 11, 8'b01_10_11_01, 0, 0, -1, "illegal_digit");
    e = mk(11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== e) begin bad++; report("illegal_sticky", i, obs, e); end
    end
  endtask

  task automatic test_start_ignored();
    run_op(1'b1, 11, 8'b01_11_00_01, 0, 0, 3, "start_ignored");
  endtask

  task automatic test_reset_mid_run();
    rec_t z;
    z = mk(0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    sel_b = 1'b1;
    operand = 8'b01_11_00_01; en = 1'b1; err = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs.cnt !== 9'd3) begin
      bad++;
      report("mid_run_cnt", 3, obs, mk(3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    end
    reset = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== z) begin bad++; report("reset_mid_run", 0, obs, z); end
    reset = 1'b0; start_b = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== z) begin bad++; report("idle_after_mid_reset", 0, obs, z); end
    run_op(1'b1, 11, 8'b01_11_00_01, 0, 0, -1, "restart_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 7, 8'b11_11_11_11, 0, 0, -1, "back_to_back_1");
    run_op(1'b0, 7, 8'b10_00_00_01, 1, 0, -1, "back_to_back_2");
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_sparse_enable();
    test_error_stall();
    test_illegal();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_feeder.md
DIGIT_FEEDER -- requirements
Module: digit_feeder

Interface
REQ-001 Parameter DIGITS, default 16: number of operand digits held per operation (1..64).
REQ-002 Parameter LAST_CNT, default 67: final cnt_master value of an operation (must be >= DIGITS, <= 511).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  load operand and begin an operation (honoured in IDLE only).
REQ-006 operand_in  input  2*DIGITS  signed-digit operand, MSD at top bits; per digit 00=0, 01=+1, 11=-1, 10=illegal.
REQ-007 enable_for_input  input  1  consumer request for the next digit in the current step.
REQ-008 error_flag  input  1  consumer correction in progress; blocks digit consumption.
REQ-009 cnt_master  output  9  step counter driven to the consumer.
REQ-010 write_enable  output  1  step strobe; consumer advances only when high.
REQ-011 digit_out  output  2  current digit presented to the consumer.
REQ-012 digit_valid  output  1  digit_out carries a consumed operand digit this cycle.
REQ-013 busy  output  1  operation in progress (RUN state).
REQ-014 done  output  1  one-cycle pulse at end of operation.
REQ-015 illegal_digit  output  1  sticky flag: an illegal 10 digit was issued.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 SHALL latch operand_in into a shift register, set digits_left=DIGITS, cnt_master=0, clear illegal_digit, and enter RUN next cycle.
REQ-018 In RUN, write_enable SHALL be 1 and busy SHALL be 1 every cycle; in IDLE and DONE both SHALL be 0.
REQ-019 In RUN, cnt_master SHALL increment by 1 each cycle, so the first RUN cycle presents 0 and consecutive cycles present 1, 2, ...
REQ-020 A digit SHALL be consumed at an edge in RUN where enable_for_input=1, error_flag=0 and digits_left>0; next cycle digit_out=that MSD, digit_valid=1, shift register shifts left by 2, digits_left decrements.
REQ-021 At any other RUN edge, next cycle digit_out=00 and digit_valid=0 (zero padding); digits_left unchanged.
REQ-022 error_flag=1 SHALL take priority over enable_for_input=1; the skipped digit is issued at the next qualifying edge, no digit lost or duplicated.
REQ-023 A consumed illegal digit 10 SHALL be issued as 00 with digit_valid=1 and set illegal_digit, which holds until the next accepted start or reset.
REQ-024 When cnt_master==LAST_CNT in RUN, the next state SHALL be DONE, regardless of digits_left; unconsumed digits are discarded.
REQ-025 DONE SHALL last exactly one cycle with done=1, write_enable=0, digit_valid=0, then return to IDLE; cnt_master holds LAST_CNT through DONE and IDLE until the next start.
REQ-026 start in RUN or DONE SHALL be ignored; start in IDLE in the same cycle as DONE exits is not possible (DONE precedes IDLE).
REQ-027 cnt_master SHALL never wrap; LAST_CNT bounds it below 512.

Reset
REQ-028 reset=1 at any edge, including mid-RUN, SHALL force IDLE, cnt_master=0, write_enable=0, digit_out=00, digit_valid=0, busy=0, done=0, illegal_digit=0, digits_left=0, on the next cycle; reset overrides start.

Verification
REQ-029 DIGITS=4, LAST_CNT=7, operand 01_11_00_01, enable_for_input held 1 -> digit_out 01,11,00,01 with digit_valid=1 at cnt_master 1..4, then 00/valid=0 at 5..7, done pulse one cycle after cnt_master=7.
REQ-030 Same operand, enable_for_input=1 only on cnt_master 0,4,8 with LAST_CNT=11 -> digits 01,11,00 issued at cnt_master 1,5,9; fourth digit discarded; done after 11.
REQ-031 enable_for_input=1 continuously, error_flag=1 during cnt_master 1..2 -> digits at cnt_master 1,2,3,4 are 01,00(valid=0),00(valid=0),11; ordering preserved.
REQ-032 Operand with 10 as second digit -> second issued digit 00 with digit_valid=1, illegal_digit=1 until next start.
REQ-033 reset asserted at cnt_master=3 in RUN -> next cycle all outputs at reset values, busy=0; subsequent start restarts at cnt_master=0 with first digit.
REQ-034 start pulsed during RUN -> ignored; operand and cnt_master sequence unchanged.
